// File: rtl/amm_perf_monitor.sv
// amm_perf_monitor: passive Avalon-MM monitor. It tracks outstanding read
// bursts in a circular tracker, measures the first-word latency of each burst,
// keeps min/max/sum and a latency histogram, and counts read/write throughput.
// Every counter saturates instead of wrapping.
module amm_perf_monitor #(
  parameter int AMM_BURST_W = 4,
  parameter int DATA_B_W    = 8,
  parameter     ADDR_TYPE   = "BYTE",
  parameter int TRK_DEPTH   = 8,
  parameter int LAT_W       = 16,
  parameter int SUM_W       = 32,
  parameter int HIST_BINS   = 8,
  parameter int HIST_SHIFT  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         read_i,
  input  logic                         write_i,
  input  logic                         waitrequest_i,
  input  logic                         readdatavalid_i,
  input  logic [AMM_BURST_W-1:0]       burstcount_i,
  input  logic [DATA_B_W-1:0]          byteenable_i,
  input  logic                         test_start_i,
  input  logic [$clog2(HIST_BINS)-1:0] hist_sel_i,
  output logic                         meas_busy_o,
  output logic [31:0]                  wr_ticks_o,
  output logic [31:0]                  wr_units_o,
  output logic [31:0]                  rd_ticks_o,
  output logic [31:0]                  rd_words_o,
  output logic [31:0]                  rd_req_o,
  output logic [LAT_W-1:0]             min_del_o,
  output logic [LAT_W-1:0]             max_del_o,
  output logic [SUM_W-1:0]             sum_del_o,
  output logic [31:0]                  hist_cnt_o,
  output logic                         trk_ovf_o,
  output logic                         spur_rdv_o
);

  localparam int PTR_W = $clog2(TRK_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int BIN_W = $clog2(HIST_BINS);
  localparam int PC_W  = $clog2(DATA_B_W + 1);
  localparam logic [LAT_W-1:0] LAT_MAX  = '1;
  localparam logic [LAT_W-1:0] BIN_LAST = LAT_W'(HIST_BINS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TRK_DEPTH);

  // Saturating 32-bit add used by all event counters
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [PC_W-1:0] popcnt(input logic [DATA_B_W-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_B_W; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Issue phase: age of the request currently waiting for acceptance
  logic             iss_act_reg;
  logic [LAT_W-1:0] iss_age_reg;

  // Tracker
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]       occ_reg;
  logic [AMM_BURST_W-1:0] slot_cnt_reg   [TRK_DEPTH];
  logic [LAT_W-1:0]       slot_age_reg   [TRK_DEPTH];
  logic                   slot_first_reg [TRK_DEPTH];

  // Latency pipeline and statistics
  logic             lat_vld_reg;
  logic [LAT_W-1:0] lat_reg;
  logic [LAT_W-1:0] min_reg, max_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [31:0]      hist_reg [HIST_BINS];

  // Write pipeline and counters
  logic            wr_vld_reg;
  logic [PC_W-1:0] wr_pcnt_reg;
  logic [31:0]     wr_ticks_reg, wr_units_reg, rd_ticks_reg, rd_words_reg, rd_req_reg;
  logic            trk_ovf_reg, spur_rdv_reg;

  // Decoded events
  logic                   rd_acc, wr_acc, trk_full, trk_empty, push, pop;
  logic                   head_beat, head_first, stat_upd;
  logic [LAT_W-1:0]       cur_age, next_age;
  logic [AMM_BURST_W-1:0] push_cnt, head_cnt;
  logic [PC_W-1:0]        wr_units_in;
  logic [BIN_W-1:0]       lat_bin;
  logic [SUM_W:0]         sum_add;

  assign rd_acc     = read_i && !waitrequest_i;
  assign wr_acc     = write_i && !waitrequest_i;
  assign trk_full   = (occ_reg == OCC_FULL);
  assign trk_empty  = (occ_reg == '0);
  // An acceptance while full is counted but cannot be tracked
  assign push       = rd_acc && !trk_full;
  // Age is 0 on the first read_i cycle; the stored value is the age one cycle on
  assign cur_age    = iss_act_reg ? iss_age_reg : '0;
  assign next_age   = (cur_age == LAT_MAX) ? LAT_MAX : cur_age + 1'b1;
  assign push_cnt   = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
  // Data always belongs to the oldest outstanding burst
  assign head_cnt   = slot_cnt_reg[rd_ptr_reg];
  assign head_beat  = readdatavalid_i && !trk_empty;
  assign head_first = head_beat && !slot_first_reg[rd_ptr_reg];
  assign pop        = head_beat && (head_cnt <= AMM_BURST_W'(1));
  assign wr_units_in = (ADDR_TYPE == "WORD") ? PC_W'(1) : popcnt(byteenable_i);
  // Once the tracker has overflowed, latencies can no longer be trusted
  assign stat_upd   = lat_vld_reg && !trk_ovf_reg;
  assign lat_bin    = ((lat_reg >> HIST_SHIFT) > BIN_LAST) ? BIN_W'(HIST_BINS - 1)
                                                           : BIN_W'(lat_reg >> HIST_SHIFT);
  assign sum_add    = {1'b0, sum_reg} + (SUM_W + 1)'(lat_reg);

  genvar gi;

  generate
    for (gi = 0; gi < TRK_DEPTH; gi++) begin : g_slot
      // Slot state: load on push, age until the first beat, count down on beats
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          slot_cnt_reg[gi]   <= '0;
          slot_age_reg[gi]   <= '0;
          slot_first_reg[gi] <= 1'b0;
        end else if (test_start_i) begin
          slot_cnt_reg[gi]   <= '0;
          slot_age_reg[gi]   <= '0;
          slot_first_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_cnt_reg[gi]   <= push_cnt;
          slot_age_reg[gi]   <= next_age;
          slot_first_reg[gi] <= 1'b0;
        end else if (head_beat && (rd_ptr_reg == PTR_W'(gi))) begin
          slot_cnt_reg[gi]   <= slot_cnt_reg[gi] - 1'b1;
          slot_first_reg[gi] <= 1'b1;
        end else if (!slot_first_reg[gi] && (slot_age_reg[gi] != LAT_MAX)) begin
          slot_age_reg[gi]   <= slot_age_reg[gi] + 1'b1;
        end
      end
    end

    for (gi = 0; gi < HIST_BINS; gi++) begin : g_hist
      // Histogram bin: counts tracked latencies landing in this bin
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          hist_reg[gi] <= '0;
        end else if (test_start_i) begin
          hist_reg[gi] <= '0;
        end else if (stat_upd && (lat_bin == BIN_W'(gi))) begin
          hist_reg[gi] <= sat_add32(hist_reg[gi], 32'd1);
        end
      end
    end
  endgenerate

  // Issue ageing, tracker pointers, counters, sticky flags and both pipelines
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      iss_act_reg  <= 1'b0;
      iss_age_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      lat_vld_reg  <= 1'b0;
      lat_reg      <= '0;
      min_reg      <= '1;
      max_reg      <= '0;
      sum_reg      <= '0;
      wr_vld_reg   <= 1'b0;
      wr_pcnt_reg  <= '0;
      wr_ticks_reg <= '0;
      wr_units_reg <= '0;
      rd_ticks_reg <= '0;
      rd_words_reg <= '0;
      rd_req_reg   <= '0;
      trk_ovf_reg  <= 1'b0;
      spur_rdv_reg <= 1'b0;
    end else if (test_start_i) begin
      iss_act_reg  <= 1'b0;
      iss_age_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      lat_vld_reg  <= 1'b0;
      lat_reg      <= '0;
      min_reg      <= '1;
      max_reg      <= '0;
      sum_reg      <= '0;
      wr_vld_reg   <= 1'b0;
      wr_pcnt_reg  <= '0;
      wr_ticks_reg <= '0;
      wr_units_reg <= '0;
      rd_ticks_reg <= '0;
      rd_words_reg <= '0;
      rd_req_reg   <= '0;
      trk_ovf_reg  <= 1'b0;
      spur_rdv_reg <= 1'b0;
    end else begin
      if (rd_acc || !read_i) begin
        iss_act_reg <= 1'b0;
        iss_age_reg <= '0;
      end else begin
        iss_act_reg <= 1'b1;
        iss_age_reg <= next_age;
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);

      if (rd_acc)                        rd_req_reg   <= sat_add32(rd_req_reg, 32'd1);
      if (rd_acc && trk_full)            trk_ovf_reg  <= 1'b1;
      if (readdatavalid_i)               rd_words_reg <= sat_add32(rd_words_reg, 32'd1);
      if (readdatavalid_i && trk_empty)  spur_rdv_reg <= 1'b1;
      if (!trk_empty)                    rd_ticks_reg <= sat_add32(rd_ticks_reg, 32'd1);

      lat_vld_reg <= head_first;
      if (head_first) lat_reg <= slot_age_reg[rd_ptr_reg];
      if (stat_upd) begin
        if (lat_reg < min_reg) min_reg <= lat_reg;
        if (lat_reg > max_reg) max_reg <= lat_reg;
        sum_reg <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      end

      if (write_i) wr_ticks_reg <= sat_add32(wr_ticks_reg, 32'd1);
      wr_vld_reg <= wr_acc;
      if (wr_acc)     wr_pcnt_reg  <= wr_units_in;
      if (wr_vld_reg) wr_units_reg <= sat_add32(wr_units_reg, 32'(wr_pcnt_reg));
    end
  end

  assign meas_busy_o = (occ_reg != '0) || lat_vld_reg || wr_vld_reg;
  assign wr_ticks_o  = wr_ticks_reg;
  assign wr_units_o  = wr_units_reg;
  assign rd_ticks_o  = rd_ticks_reg;
  assign rd_words_o  = rd_words_reg;
  assign rd_req_o    = rd_req_reg;
  assign min_del_o   = min_reg;
  assign max_del_o   = max_reg;
  assign sum_del_o   = sum_reg;
  assign hist_cnt_o  = hist_reg[hist_sel_i];
  assign trk_ovf_o   = trk_ovf_reg;
  assign spur_rdv_o  = spur_rdv_reg;

endmodule

// File: tb/tb_amm_perf_monitor.sv
// Testbench for amm_perf_monitor: directed scenarios with hand-derived
// expectations plus randomized traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_amm_perf_monitor;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        read_i = 1'b0, write_i = 1'b0, waitrequest_i = 1'b0, readdatavalid_i = 1'b0;
  logic [3:0]  burstcount_i = '0;
  logic [7:0]  byteenable_i = '0;
  logic        test_start_i = 1'b0;
  logic [2:0]  hist_sel_i = '0;
  logic        meas_busy_o;
  logic [31:0] wr_ticks_o, wr_units_o, rd_ticks_o, rd_words_o, rd_req_o, hist_cnt_o;
  logic [15:0] min_del_o, max_del_o;
  logic [31:0] sum_del_o;
  logic        trk_ovf_o, spur_rdv_o;

  always #5 clk_i = ~clk_i;

  amm_perf_monitor dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .read_i(read_i), .write_i(write_i),
    .waitrequest_i(waitrequest_i), .readdatavalid_i(readdatavalid_i),
    .burstcount_i(burstcount_i), .byteenable_i(byteenable_i),
    .test_start_i(test_start_i), .hist_sel_i(hist_sel_i),
    .meas_busy_o(meas_busy_o), .wr_ticks_o(wr_ticks_o), .wr_units_o(wr_units_o),
    .rd_ticks_o(rd_ticks_o), .rd_words_o(rd_words_o), .rd_req_o(rd_req_o),
    .min_del_o(min_del_o), .max_del_o(max_del_o), .sum_del_o(sum_del_o),
    .hist_cnt_o(hist_cnt_o), .trk_ovf_o(trk_ovf_o), .spur_rdv_o(spur_rdv_o)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level reference: a queue of outstanding bursts, each knowing
  // when its request first appeared and how many words are still owed.
  typedef struct { longint start; int rem; bit seen; } burst_t;
  burst_t mq[$];
  longint m_cyc = 0;
  bit     m_iss_act;
  longint m_iss_start;
  longint m_rd_req, m_rd_words, m_rd_ticks, m_wr_ticks, m_wr_units, m_sum, m_min, m_max;
  longint m_hist[8];
  bit     m_ovf, m_spur;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_iss_act = 0; m_iss_start = 0;
    m_rd_req = 0; m_rd_words = 0; m_rd_ticks = 0; m_wr_ticks = 0; m_wr_units = 0;
    m_sum = 0; m_min = 65535; m_max = 0; m_ovf = 0; m_spur = 0;
    for (int b = 0; b < 8; b++) m_hist[b] = 0;
  endtask

  // One bus cycle: apply inputs, advance the model, step to 1ns after the edge
  task automatic drive_cycle(input bit rd, input bit wr, input bit wq, input bit dv,
                             input logic [3:0] bc, input logic [7:0] be, input bit ts);
    int n0;
    bit acc;
    longint lat;
    read_i = rd; write_i = wr; waitrequest_i = wq; readdatavalid_i = dv;
    burstcount_i = bc; byteenable_i = be; test_start_i = ts;
    if (ts) begin
      model_clear();
    end else begin
      n0 = mq.size();
      if (n0 > 0) m_rd_ticks = sat(m_rd_ticks + 1, MAX32);
      if (wr) m_wr_ticks = sat(m_wr_ticks + 1, MAX32);
      if (wr && !wq) m_wr_units = sat(m_wr_units + $countones(be), MAX32);
      if (rd && !m_iss_act) m_iss_start = m_cyc;
      acc = rd && !wq;
      if (acc) begin
        m_rd_req = sat(m_rd_req + 1, MAX32);
        if (n0 == 8) m_ovf = 1;
      end
      if (dv) begin
        m_rd_words = sat(m_rd_words + 1, MAX32);
        if (n0 == 0) m_spur = 1;
        else begin
          if (!mq[0].seen) begin
            mq[0].seen = 1;
            lat = sat(m_cyc - mq[0].start, 65535);
            if (!m_ovf) begin
              if (lat < m_min) m_min = lat;
              if (lat > m_max) m_max = lat;
              m_sum = sat(m_sum + lat, MAX32);
              m_hist[sat(lat >> 2, 7)]++;
            end
          end
          mq[0].rem--;
          if (mq[0].rem == 0) void'(mq.pop_front());
        end
      end
      if (acc && n0 != 8) mq.push_back('{m_iss_start, (bc == 0) ? 1 : int'(bc), 1'b0});
      m_iss_act = rd && wq;
    end
    @(posedge clk_i);
    #1;
    m_cyc++;
    test_start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (rd_req_o !== 32'd0) begin failures++; $display("FAIL reset_rd_req got=%0h exp=0", rd_req_o); end
    checks++; if (min_del_o !== 16'hFFFF) begin failures++; $display("FAIL reset_min got=%0h exp=ffff", min_del_o); end
    checks++; if ({meas_busy_o, trk_ovf_o, spur_rdv_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {meas_busy_o, trk_ovf_o, spur_rdv_o}); end
    checks++; if ((wr_units_o | wr_ticks_o | rd_words_o | sum_del_o | {16'd0, max_del_o}) !== 32'd0) begin failures++; $display("FAIL reset_counters got_nonzero exp=0"); end
    rst_n_i = 1'b1;
    model_clear();
    idle(2);
    $display("test_reset done");
  endtask

  // bl=4 read, 2 waitrequest cycles, first data at cycle 8 from the first read_i -> latency 8
  task automatic test_single_burst();
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    drive_cycle(1, 0, 1, 0, 4'd4, 8'd0, 0);
    drive_cycle(1, 0, 1, 0, 4'd4, 8'd0, 0);
    drive_cycle(1, 0, 0, 0, 4'd4, 8'd0, 0);
    idle(2);
    checks++; if (meas_busy_o !== 1'b1) begin failures++; $display("FAIL single_busy_mid got=%b exp=1", meas_busy_o); end
    idle(3);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 1, 4'd0, 8'd0, 0);
    idle(2);
    checks++; if (meas_busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", meas_busy_o); end
    checks++; if ({min_del_o, max_del_o} !== {16'd8, 16'd8}) begin failures++; $display("FAIL single_minmax got=%0d/%0d exp=8/8", min_del_o, max_del_o); end
    checks++; if (sum_del_o !== 32'd8) begin failures++; $display("FAIL single_sum got=%0d exp=8", sum_del_o); end
    checks++; if ({rd_words_o, rd_req_o} !== {32'd4, 32'd1}) begin failures++; $display("FAIL single_words_req got=%0d/%0d exp=4/1", rd_words_o, rd_req_o); end
    hist_sel_i = 3'd2; #1;
    checks++; if (hist_cnt_o !== 32'd1) begin failures++; $display("FAIL single_hist2 got=%0d exp=1", hist_cnt_o); end
    $display("test_single_burst done lat=%0d", min_del_o);
  endtask

  // Four bl=1 reads with latencies 3,9,5,40
  task automatic test_back_to_back();
    logic [31:0] exp_h [8];
    exp_h = '{1, 1, 1, 0, 0, 0, 0, 1};
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    for (int c = 0; c < 50; c++) begin
      bit rd, dv;
      rd = (c == 0) || (c == 1) || (c == 6) || (c == 7);
      dv = (c == 3) || (c == 10) || (c == 11) || (c == 47);
      drive_cycle(rd, 0, 0, dv, 4'd1, 8'd0, 0);
    end
    idle(2);
    checks++; if ({min_del_o, max_del_o} !== {16'd3, 16'd40}) begin failures++; $display("FAIL b2b_minmax got=%0d/%0d exp=3/40", min_del_o, max_del_o); end
    checks++; if (sum_del_o !== 32'd57) begin failures++; $display("FAIL b2b_sum got=%0d exp=57", sum_del_o); end
    for (int b = 0; b < 8; b++) begin
      hist_sel_i = 3'(b); #1;
      checks++; if (hist_cnt_o !== exp_h[b]) begin failures++; $display("FAIL b2b_hist%0d got=%0d exp=%0d", b, hist_cnt_o, exp_h[b]); end
    end
    $display("test_back_to_back done sum=%0d", sum_del_o);
  endtask

  // Nine accepted reads without data overflow an 8-deep tracker
  task automatic test_overflow();
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    for (int i = 0; i < 9; i++) drive_cycle(1, 0, 0, 0, 4'd1, 8'd0, 0);
    idle(2);
    checks++; if (trk_ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", trk_ovf_o); end
    checks++; if (rd_req_o !== 32'd9) begin failures++; $display("FAIL ovf_rd_req got=%0d exp=9", rd_req_o); end
    for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 1, 4'd0, 8'd0, 0);
    idle(3);
    checks++; if ({min_del_o, max_del_o} !== {16'hFFFF, 16'd0}) begin failures++; $display("FAIL ovf_frozen got=%0h/%0h exp=ffff/0", min_del_o, max_del_o); end
    checks++; if ({rd_words_o, sum_del_o} !== {32'd8, 32'd0}) begin failures++; $display("FAIL ovf_words_sum got=%0d/%0d exp=8/0", rd_words_o, sum_del_o); end
    checks++; if ({meas_busy_o, spur_rdv_o} !== 2'b00) begin failures++; $display("FAIL ovf_busy_spur got=%b exp=00", {meas_busy_o, spur_rdv_o}); end
    $display("test_overflow done");
  endtask

  task automatic test_spurious();
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    drive_cycle(0, 0, 0, 1, 4'd0, 8'd0, 0);
    idle(2);
    checks++; if ({spur_rdv_o, trk_ovf_o} !== 2'b10) begin failures++; $display("FAIL spur_flags got=%b exp=10", {spur_rdv_o, trk_ovf_o}); end
    checks++; if (rd_words_o !== 32'd1) begin failures++; $display("FAIL spur_words got=%0d exp=1", rd_words_o); end
    checks++; if (min_del_o !== 16'hFFFF) begin failures++; $display("FAIL spur_min got=%0h exp=ffff", min_del_o); end
    $display("test_spurious done");
  endtask

  // BYTE mode: be FF (after one waitrequest), 0F, 01 -> 13 bytes, 4 write cycles
  task automatic test_writes();
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    drive_cycle(0, 1, 1, 0, 4'd0, 8'hFF, 0);
    drive_cycle(0, 1, 0, 0, 4'd0, 8'hFF, 0);
    checks++; if (wr_units_o !== 32'd0) begin failures++; $display("FAIL wr_lat1 got=%0d exp=0", wr_units_o); end
    drive_cycle(0, 1, 0, 0, 4'd0, 8'h0F, 0);
    checks++; if (wr_units_o !== 32'd8) begin failures++; $display("FAIL wr_lat2 got=%0d exp=8", wr_units_o); end
    drive_cycle(0, 1, 0, 0, 4'd0, 8'h01, 0);
    idle(3);
    checks++; if ({wr_units_o, wr_ticks_o} !== {32'd13, 32'd4}) begin failures++; $display("FAIL wr_totals got=%0d/%0d exp=13/4", wr_units_o, wr_ticks_o); end
    $display("test_writes done units=%0d", wr_units_o);
  endtask

  task automatic test_saturation();
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    force dut.rd_words_reg = 32'hFFFF_FFFE;
    #1;
    release dut.rd_words_reg;
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 4'd0, 8'd0, 0);
    checks++; if (rd_words_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_words got=%0h exp=ffffffff", rd_words_o); end
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    checks++; if ({rd_words_o, rd_req_o, wr_ticks_o} !== 96'd0) begin failures++; $display("FAIL sat_clear got=%0h exp=0", rd_words_o); end
    checks++; if ({spur_rdv_o, min_del_o} !== {1'b0, 16'hFFFF}) begin failures++; $display("FAIL sat_clear_flags got=%b/%0h exp=0/ffff", spur_rdv_o, min_del_o); end
    $display("test_saturation done");
  endtask

  // test_start wins over an accepted read, a beat and a write in the same cycle
  task automatic test_start_priority();
    drive_cycle(1, 0, 0, 1, 4'd2, 8'd0, 1);
    drive_cycle(0, 1, 0, 0, 4'd0, 8'hFF, 1);
    idle(2);
    checks++; if ({rd_req_o, rd_words_o, wr_ticks_o, wr_units_o} !== 128'd0) begin failures++; $display("FAIL start_prio got=%0d/%0d/%0d/%0d exp=0", rd_req_o, rd_words_o, wr_ticks_o, wr_units_o); end
    checks++; if ({meas_busy_o, spur_rdv_o} !== 2'b00) begin failures++; $display("FAIL start_prio_flags got=%b exp=00", {meas_busy_o, spur_rdv_o}); end
    $display("test_start_priority done");
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, 0, 4'd4, 8'd0, 0);
    idle(1);
    checks++; if (meas_busy_o !== 1'b1) begin failures++; $display("FAIL arst_busy_before got=%b exp=1", meas_busy_o); end
    rst_n_i = 1'b0;
    #2;
    checks++; if ({meas_busy_o, rd_req_o} !== 33'd0) begin failures++; $display("FAIL arst_clear got=%b/%0d exp=0/0", meas_busy_o, rd_req_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_clear();
    idle(1);
    checks++; if ({trk_ovf_o, spur_rdv_o, min_del_o} !== {2'b00, 16'hFFFF}) begin failures++; $display("FAIL arst_flags got=%b%b/%0h exp=00/ffff", trk_ovf_o, spur_rdv_o, min_del_o); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [3:0] r_bc;
    int guard;
    r_bc = 4'd1;
    drive_cycle(0, 0, 0, 0, 4'd0, 8'd0, 1);
    for (int c = 0; c < 900; c++) begin
      bit rd, wr, wq, dv;
      wq = ($urandom_range(0, 2) == 0);
      rd = m_iss_act ? 1'b1 : ((mq.size() <= 6) && ($urandom_range(0, 3) == 0));
      if (rd && !m_iss_act) r_bc = 4'($urandom_range(0, 4));
      wr = !rd && ($urandom_range(0, 2) == 0);
      dv = (mq.size() > 0) && ($urandom_range(0, 1) == 0);
      drive_cycle(rd, wr, wq, dv, r_bc, 8'($urandom), 0);
    end
    guard = 0;
    while ((mq.size() > 0 || m_iss_act) && guard < 500) begin
      drive_cycle(m_iss_act, 0, 0, mq.size() > 0, r_bc, 8'd0, 0);
      guard++;
    end
    checks++; if (guard >= 500) begin failures++; $display("FAIL rand_drain got=%0d_outstanding exp=0", mq.size()); end
    idle(3);
    checks++; if (rd_req_o !== 32'(m_rd_req)) begin failures++; $display("FAIL rand_rd_req got=%0d exp=%0d", rd_req_o, m_rd_req); end
    checks++; if (rd_words_o !== 32'(m_rd_words)) begin failures++; $display("FAIL rand_rd_words got=%0d exp=%0d", rd_words_o, m_rd_words); end
    checks++; if (rd_ticks_o !== 32'(m_rd_ticks)) begin failures++; $display("FAIL rand_rd_ticks got=%0d exp=%0d", rd_ticks_o, m_rd_ticks); end
    checks++; if ({wr_ticks_o, wr_units_o} !== {32'(m_wr_ticks), 32'(m_wr_units)}) begin failures++; $display("FAIL rand_wr got=%0d/%0d exp=%0d/%0d", wr_ticks_o, wr_units_o, m_wr_ticks, m_wr_units); end
    checks++; if ({min_del_o, max_del_o} !== {16'(m_min), 16'(m_max)}) begin failures++; $display("FAIL rand_minmax got=%0d/%0d exp=%0d/%0d", min_del_o, max_del_o, m_min, m_max); end
    checks++; if (sum_del_o !== 32'(m_sum)) begin failures++; $display("FAIL rand_sum got=%0d exp=%0d", sum_del_o, m_sum); end
    checks++; if ({meas_busy_o, trk_ovf_o, spur_rdv_o} !== 3'b000) begin failures++; $display("FAIL rand_flags got=%b exp=000", {meas_busy_o, trk_ovf_o, spur_rdv_o}); end
    for (int b = 0; b < 8; b++) begin
      hist_sel_i = 3'(b); #1;
      checks++; if (hist_cnt_o !== 32'(m_hist[b])) begin failures++; $display("FAIL rand_hist%0d got=%0d exp=%0d", b, hist_cnt_o, m_hist[b]); end
    end
    $display("test_random done reqs=%0d words=%0d sum=%0d", m_rd_req, m_rd_words, m_sum);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_overflow();
    test_spurious();
    test_writes();
    test_saturation();
    test_start_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
